// File: rtl/tree_walker.sv
// rtl/tree_walker.sv - decision-tree walker driving an external signed comparator
//
// Purpose:
//   Walks a configurable binary decision tree held in a local node table.
//   For every non-leaf node on the path it sends the selected feature value,
//   the node weight and the node index to an external comparator. It then
//   follows the left child when the comparator returns decision=1 and the
//   right child otherwise. The walk ends when it reaches a leaf, and the
//   result is the leaf class together with the number of comparisons made.
//   The walk also ends with an error when the comparator echoes the wrong
//   node index, or when the table loops and the path reaches N_NODE
//   comparisons.
//
// Ports:
//   clk, reset                    clock; asynchronous active-high reset
//   io_cfg_node_*                 node-table write port (accepted in IDLE only)
//   io_cfg_feat_*                 feature-register write port (accepted in IDLE only)
//   io_start_valid/ready          traversal start handshake
//   io_req_*                      comparator request (feature, weights, index)
//   io_resp_*                     comparator response (decision, echoed index)
//   io_out_*                      traversal result (class, depth, error)

module tree_walker #(
    parameter int DATA_W  = 32,
    parameter int N_NODE  = 16,
    parameter int N_FEAT  = 8,
    parameter int CLASS_W = 8,
    localparam int IDX_W  = $clog2(N_NODE),
    localparam int FIDX_W = $clog2(N_FEAT)
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               io_cfg_node_we,
    input  logic [IDX_W-1:0]   io_cfg_node_addr,
    input  logic [DATA_W-1:0]  io_cfg_node_weight,
    input  logic [FIDX_W-1:0]  io_cfg_node_fidx,
    input  logic [IDX_W-1:0]   io_cfg_node_left,
    input  logic [IDX_W-1:0]   io_cfg_node_right,
    input  logic               io_cfg_node_leaf,
    input  logic [CLASS_W-1:0] io_cfg_node_class,

    input  logic               io_cfg_feat_we,
    input  logic [FIDX_W-1:0]  io_cfg_feat_addr,
    input  logic [DATA_W-1:0]  io_cfg_feat_data,

    input  logic               io_start_valid,
    output logic               io_start_ready,

    output logic               io_req_valid,
    input  logic               io_req_ready,
    output logic [DATA_W-1:0]  io_req_bits_feature,
    output logic [DATA_W-1:0]  io_req_bits_weights,
    output logic [IDX_W-1:0]   io_req_bits_index,

    input  logic               io_resp_valid,
    output logic               io_resp_ready,
    input  logic               io_resp_bits_decision,
    input  logic [IDX_W-1:0]   io_resp_bits_index,

    output logic               io_out_valid,
    input  logic               io_out_ready,
    output logic [CLASS_W-1:0] io_out_bits_class,
    output logic [IDX_W:0]     io_out_bits_depth,
    output logic               io_out_bits_error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [IDX_W-1:0]   r_cur;
    logic [IDX_W-1:0]   w_cur_nxt;
    logic [IDX_W:0]     r_depth;
    logic [IDX_W:0]     w_depth_nxt;
    logic [CLASS_W-1:0] r_class;
    logic [CLASS_W-1:0] w_class_nxt;
    logic               r_error;
    logic               w_error_nxt;

    logic [DATA_W-1:0]  r_node_weight [N_NODE];
    logic [FIDX_W-1:0]  r_node_fidx   [N_NODE];
    logic [IDX_W-1:0]   r_node_left   [N_NODE];
    logic [IDX_W-1:0]   r_node_right  [N_NODE];
    logic               r_node_leaf   [N_NODE];
    logic [CLASS_W-1:0] r_node_class  [N_NODE];
    logic [DATA_W-1:0]  r_feat        [N_FEAT];

    // The tables can only change in IDLE. Request fields are read straight
    // from them through r_cur, so the request stays stable during a stall.
    logic               w_cfg_en;
    logic               w_depth_limit;

    assign w_cfg_en      = (r_state == S_IDLE);
    assign w_depth_limit = (r_depth == (IDX_W+1)'(N_NODE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_NODE; i++) begin
                r_node_weight[i] <= '0;
                r_node_fidx[i]   <= '0;
                r_node_left[i]   <= '0;
                r_node_right[i]  <= '0;
                r_node_leaf[i]   <= 1'b0;
                r_node_class[i]  <= '0;
            end
        end else if (w_cfg_en && io_cfg_node_we) begin
            r_node_weight[io_cfg_node_addr] <= io_cfg_node_weight;
            r_node_fidx[io_cfg_node_addr]   <= io_cfg_node_fidx;
            r_node_left[io_cfg_node_addr]   <= io_cfg_node_left;
            r_node_right[io_cfg_node_addr]  <= io_cfg_node_right;
            r_node_leaf[io_cfg_node_addr]   <= io_cfg_node_leaf;
            r_node_class[io_cfg_node_addr]  <= io_cfg_node_class;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_FEAT; i++) begin
                r_feat[i] <= '0;
            end
        end else if (w_cfg_en && io_cfg_feat_we) begin
            r_feat[io_cfg_feat_addr] <= io_cfg_feat_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_depth <= '0;
            r_class <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_depth <= w_depth_nxt;
            r_class <= w_class_nxt;
            r_error <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cur_nxt      = r_cur;
        w_depth_nxt    = r_depth;
        w_class_nxt    = r_class;
        w_error_nxt    = r_error;
        io_start_ready = 1'b0;
        io_req_valid   = 1'b0;
        io_resp_ready  = 1'b0;
        io_out_valid   = 1'b0;

        case (r_state)
            S_IDLE: begin
                io_start_ready = 1'b1;
                if (io_start_valid) begin
                    w_cur_nxt   = '0;
                    w_depth_nxt = '0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_node_leaf[r_cur]) begin
                    w_class_nxt = r_node_class[r_cur];
                    w_error_nxt = 1'b0;
                    w_state_nxt = S_DONE;
                end else if (w_depth_limit) begin
                    // N_NODE comparisons without reaching a leaf: the table loops.
                    w_class_nxt = '0;
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    io_req_valid = 1'b1;
                    if (io_req_ready) begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                io_resp_ready = 1'b1;
                if (io_resp_valid) begin
                    if (io_resp_bits_index == r_cur) begin
                        w_cur_nxt   = io_resp_bits_decision ? r_node_left[r_cur]
                                                            : r_node_right[r_cur];
                        w_depth_nxt = r_depth + (IDX_W+1)'(1);
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_class_nxt = '0;
                        w_error_nxt = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                io_out_valid = 1'b1;
                if (io_out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign io_req_bits_feature = r_feat[r_node_fidx[r_cur]];
    assign io_req_bits_weights = r_node_weight[r_cur];
    assign io_req_bits_index   = r_cur;

    assign io_out_bits_class   = r_class;
    assign io_out_bits_depth   = r_depth;
    assign io_out_bits_error   = r_error;

endmodule

// File: tb/tb_tree_walker.sv
// tb/tb_tree_walker.sv - directed self-checking bench for tree_walker

module tb_tree_walker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_cfg_node_we = 1'b0;
    logic [3:0]  io_cfg_node_addr = '0;
    logic [31:0] io_cfg_node_weight = '0;
    logic [2:0]  io_cfg_node_fidx = '0;
    logic [3:0]  io_cfg_node_left = '0;
    logic [3:0]  io_cfg_node_right = '0;
    logic        io_cfg_node_leaf = 1'b0;
    logic [7:0]  io_cfg_node_class = '0;
    logic        io_cfg_feat_we = 1'b0;
    logic [2:0]  io_cfg_feat_addr = '0;
    logic [31:0] io_cfg_feat_data = '0;
    logic        io_start_valid = 1'b0;
    logic        io_start_ready;
    logic        io_req_valid;
    logic        io_req_ready = 1'b0;
    logic [31:0] io_req_bits_feature;
    logic [31:0] io_req_bits_weights;
    logic [3:0]  io_req_bits_index;
    logic        io_resp_valid = 1'b0;
    logic        io_resp_ready;
    logic        io_resp_bits_decision = 1'b0;
    logic [3:0]  io_resp_bits_index = '0;
    logic        io_out_valid;
    logic        io_out_ready = 1'b0;
    logic [7:0]  io_out_bits_class;
    logic [4:0]  io_out_bits_depth;
    logic        io_out_bits_error;

    int n_cmp = 0;
    int n_bad = 0;

    int          t_cyc_out;
    int          t_nreq;
    int          t_out_cycles;
    int          t_req_unstable;
    int          t_out_unstable;
    bit          t_timeout;
    logic [3:0]  t_idx  [0:31];
    logic [31:0] t_feat [0:31];
    logic [31:0] t_w    [0:31];
    logic [7:0]  t_class;
    logic [4:0]  t_depth;
    logic        t_err;

    tree_walker dut (
        .clk                   (clk),
        .reset                 (reset),
        .io_cfg_node_we        (io_cfg_node_we),
        .io_cfg_node_addr      (io_cfg_node_addr),
        .io_cfg_node_weight    (io_cfg_node_weight),
        .io_cfg_node_fidx      (io_cfg_node_fidx),
        .io_cfg_node_left      (io_cfg_node_left),
        .io_cfg_node_right     (io_cfg_node_right),
        .io_cfg_node_leaf      (io_cfg_node_leaf),
        .io_cfg_node_class     (io_cfg_node_class),
        .io_cfg_feat_we        (io_cfg_feat_we),
        .io_cfg_feat_addr      (io_cfg_feat_addr),
        .io_cfg_feat_data      (io_cfg_feat_data),
        .io_start_valid        (io_start_valid),
        .io_start_ready        (io_start_ready),
        .io_req_valid          (io_req_valid),
        .io_req_ready          (io_req_ready),
        .io_req_bits_feature   (io_req_bits_feature),
        .io_req_bits_weights   (io_req_bits_weights),
        .io_req_bits_index     (io_req_bits_index),
        .io_resp_valid         (io_resp_valid),
        .io_resp_ready         (io_resp_ready),
        .io_resp_bits_decision (io_resp_bits_decision),
        .io_resp_bits_index    (io_resp_bits_index),
        .io_out_valid          (io_out_valid),
        .io_out_ready          (io_out_ready),
        .io_out_bits_class     (io_out_bits_class),
        .io_out_bits_depth     (io_out_bits_depth),
        .io_out_bits_error     (io_out_bits_error)
    );

    always #5 clk = ~clk;

    task automatic write_node(input logic [3:0] addr, input logic leaf, input logic [7:0] cls,
                              input logic [2:0] fidx, input logic [31:0] w,
                              input logic [3:0] l, input logic [3:0] r);
        @(negedge clk);
        io_cfg_node_we = 1'b1; io_cfg_node_addr = addr; io_cfg_node_leaf = leaf;
        io_cfg_node_class = cls; io_cfg_node_fidx = fidx; io_cfg_node_weight = w;
        io_cfg_node_left = l; io_cfg_node_right = r;
        @(negedge clk);
        io_cfg_node_we = 1'b0;
    endtask

    task automatic write_feat(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        io_cfg_feat_we = 1'b1; io_cfg_feat_addr = addr; io_cfg_feat_data = data;
        @(negedge clk);
        io_cfg_feat_we = 1'b0;
    endtask

    // Drives one traversal with an ideal comparator model and records what it saw.
    task automatic traverse(input int req_hold, input int out_hold, input bit bad_idx, input bit wr_in_wait);
        int          cyc;
        int          stall;
        int          ostall;
        bit          done;
        bit          first_wait;
        bit          have_prev;
        logic [31:0] pf, pw;
        logic [3:0]  pi;
        logic [3:0]  cur_idx;
        logic        dec;
        t_cyc_out = -1; t_nreq = 0; t_out_cycles = 0;
        t_req_unstable = 0; t_out_unstable = 0; t_timeout = 0;
        t_class = 'x; t_depth = 'x; t_err = 1'bx;
        stall = 0; ostall = 0; done = 0; first_wait = 1; have_prev = 0;
        pf = '0; pw = '0; pi = '0; cur_idx = '0; dec = 1'b0;
        @(negedge clk);
        io_start_valid = 1'b1;
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            io_start_valid = 1'b0; io_req_ready = 1'b0; io_resp_valid = 1'b0;
            io_out_ready = 1'b0; io_cfg_node_we = 1'b0; io_cfg_feat_we = 1'b0;
            if (io_req_valid) begin
                if (have_prev && (io_req_bits_feature !== pf || io_req_bits_weights !== pw ||
                                  io_req_bits_index !== pi))
                    t_req_unstable++;
                pf = io_req_bits_feature; pw = io_req_bits_weights; pi = io_req_bits_index;
                have_prev = 1;
                if (stall < req_hold) begin
                    stall++;
                end else begin
                    io_req_ready = 1'b1;
                    if (t_nreq < 32) begin
                        t_idx[t_nreq] = io_req_bits_index;
                        t_feat[t_nreq] = io_req_bits_feature;
                        t_w[t_nreq] = io_req_bits_weights;
                    end
                    dec = ($signed(io_req_bits_feature) <= $signed(io_req_bits_weights));
                    cur_idx = io_req_bits_index;
                    t_nreq++;
                    have_prev = 0;
                end
            end else begin
                have_prev = 0;
            end
            if (io_resp_ready) begin
                io_resp_valid = 1'b1;
                io_resp_bits_decision = dec;
                io_resp_bits_index = bad_idx ? 4'd3 : cur_idx;
                if (wr_in_wait && first_wait) begin
                    io_cfg_node_we = 1'b1; io_cfg_node_addr = 4'd4; io_cfg_node_leaf = 1'b1;
                    io_cfg_node_class = 8'h99; io_cfg_node_fidx = 3'd0; io_cfg_node_weight = '0;
                    io_cfg_node_left = '0; io_cfg_node_right = '0;
                    io_cfg_feat_we = 1'b1; io_cfg_feat_addr = 3'd2; io_cfg_feat_data = 32'hFFFF_FFF6;
                end
                first_wait = 0;
            end
            if (io_out_valid) begin
                if (t_out_cycles == 0) begin
                    t_cyc_out = cyc;
                    t_class = io_out_bits_class; t_depth = io_out_bits_depth; t_err = io_out_bits_error;
                end else if (io_out_bits_class !== t_class || io_out_bits_depth !== t_depth ||
                             io_out_bits_error !== t_err) begin
                    t_out_unstable++;
                end
                t_out_cycles++;
                if (ostall < out_hold) ostall++;
                else begin io_out_ready = 1'b1; done = 1; end
            end
        end
        if (!done) t_timeout = 1;
        @(negedge clk);
        io_out_ready = 1'b0; io_req_ready = 1'b0; io_resp_valid = 1'b0;
        io_cfg_node_we = 1'b0; io_cfg_feat_we = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2;
        n_cmp++;
        if (io_start_ready !== 1'b1 || io_req_valid !== 1'b0 || io_resp_ready !== 1'b0 || io_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: start_ready=%b req_valid=%b resp_ready=%b out_valid=%b, required 1 0 0 0",
                     io_start_ready, io_req_valid, io_resp_ready, io_out_valid);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (io_req_bits_weights !== 32'd0 || io_req_bits_index !== 4'd0 || io_out_bits_depth !== 5'd0 ||
            io_out_bits_class !== 8'd0 || io_out_bits_error !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: weights=%h index=%0d depth=%0d class=%h error=%b, required 0 0 0 0 0",
                     io_req_bits_weights, io_req_bits_index, io_out_bits_depth, io_out_bits_class, io_out_bits_error);
        end
    endtask

    task automatic test_root_leaf;
        write_node(4'd0, 1'b1, 8'h2A, 3'd0, 32'd0, 4'd0, 4'd0);
        traverse(0, 0, 0, 0);
        n_cmp++;
        if (t_timeout || t_cyc_out !== 2) begin
            n_bad++; $display("FAIL root_leaf_latency: got %0d cycles (timeout=%0d), required 2", t_cyc_out, t_timeout);
        end
        n_cmp++;
        if (t_class !== 8'h2A || t_depth !== 5'd0 || t_err !== 1'b0 || t_nreq !== 0) begin
            n_bad++;
            $display("FAIL root_leaf_result: class=%h depth=%0d err=%b reqs=%0d, required 2a 0 0 0",
                     t_class, t_depth, t_err, t_nreq);
        end
    endtask

    task automatic test_depth2;
        write_node(4'd0, 1'b0, 8'h00, 3'd1, 32'd10, 4'd1, 4'd2);
        write_node(4'd1, 1'b0, 8'h00, 3'd2, 32'hFFFF_FFFB, 4'd3, 4'd4);
        write_node(4'd4, 1'b1, 8'h07, 3'd0, 32'd0, 4'd0, 4'd0);
        write_feat(3'd1, 32'd10);
        write_feat(3'd2, 32'd0);
        traverse(0, 0, 0, 0);
        n_cmp++;
        if (t_nreq !== 2 || t_idx[0] !== 4'd0 || t_idx[1] !== 4'd1) begin
            n_bad++; $display("FAIL depth2_req_index: reqs=%0d idx0=%0d idx1=%0d, required 2 0 1", t_nreq, t_idx[0], t_idx[1]);
        end
        n_cmp++;
        if (t_feat[0] !== 32'd10 || t_w[0] !== 32'd10 || t_feat[1] !== 32'd0 || t_w[1] !== 32'hFFFF_FFFB) begin
            n_bad++;
            $display("FAIL depth2_req_fields: f0=%h w0=%h f1=%h w1=%h, required 0000000a 0000000a 00000000 fffffffb",
                     t_feat[0], t_w[0], t_feat[1], t_w[1]);
        end
        n_cmp++;
        if (t_class !== 8'h07 || t_depth !== 5'd2 || t_err !== 1'b0) begin
            n_bad++; $display("FAIL depth2_result: class=%h depth=%0d err=%b, required 07 2 0", t_class, t_depth, t_err);
        end
        n_cmp++;
        if (t_timeout || t_cyc_out !== 6) begin
            n_bad++; $display("FAIL depth2_latency: got %0d cycles, required 6", t_cyc_out);
        end
    endtask

    task automatic test_backpressure;
        traverse(5, 3, 0, 0);
        n_cmp++;
        if (t_req_unstable !== 0 || t_out_unstable !== 0) begin
            n_bad++; $display("FAIL bp_stability: req changes=%0d out changes=%0d, required 0 0", t_req_unstable, t_out_unstable);
        end
        n_cmp++;
        if (t_class !== 8'h07 || t_depth !== 5'd2 || t_err !== 1'b0 || t_nreq !== 2) begin
            n_bad++;
            $display("FAIL bp_result: class=%h depth=%0d err=%b reqs=%0d, required 07 2 0 2", t_class, t_depth, t_err, t_nreq);
        end
        n_cmp++;
        if (t_timeout || t_cyc_out !== 11 || t_out_cycles !== 4) begin
            n_bad++; $display("FAIL bp_timing: out at %0d held %0d cycles, required 11 and 4", t_cyc_out, t_out_cycles);
        end
    endtask

    task automatic test_bad_index;
        traverse(0, 0, 1, 0);
        n_cmp++;
        if (t_err !== 1'b1 || t_class !== 8'h00 || t_depth !== 5'd0 || t_nreq !== 1) begin
            n_bad++;
            $display("FAIL bad_index: err=%b class=%h depth=%0d reqs=%0d, required 1 00 0 1", t_err, t_class, t_depth, t_nreq);
        end
        n_cmp++;
        if (t_timeout || t_cyc_out !== 3) begin
            n_bad++; $display("FAIL bad_index_latency: got %0d cycles, required 3", t_cyc_out);
        end
    endtask

    task automatic test_cfg_ignored;
        traverse(0, 0, 0, 1);
        n_cmp++;
        if (t_class !== 8'h07 || t_depth !== 5'd2 || t_err !== 1'b0 || t_feat[1] !== 32'd0) begin
            n_bad++;
            $display("FAIL cfg_write_in_wait: class=%h depth=%0d err=%b f1=%h, required 07 2 0 00000000",
                     t_class, t_depth, t_err, t_feat[1]);
        end
    endtask

    task automatic test_loop;
        write_node(4'd0, 1'b0, 8'h00, 3'd0, 32'd0, 4'd0, 4'd0);
        traverse(0, 0, 0, 0);
        n_cmp++;
        if (t_err !== 1'b1 || t_class !== 8'h00 || t_depth !== 5'd16 || t_nreq !== 16) begin
            n_bad++;
            $display("FAIL loop: err=%b class=%h depth=%0d reqs=%0d, required 1 00 16 16", t_err, t_class, t_depth, t_nreq);
        end
        n_cmp++;
        if (t_timeout || t_cyc_out !== 34) begin
            n_bad++; $display("FAIL loop_latency: got %0d cycles, required 34", t_cyc_out);
        end
    endtask

    task automatic test_start_and_write;
        int  cyc;
        bit  saw_req;
        @(negedge clk);
        io_start_valid = 1'b1;
        io_cfg_node_we = 1'b1; io_cfg_node_addr = 4'd0; io_cfg_node_leaf = 1'b1;
        io_cfg_node_class = 8'h55; io_cfg_node_fidx = 3'd0; io_cfg_node_weight = '0;
        io_cfg_node_left = '0; io_cfg_node_right = '0;
        cyc = 0; saw_req = 0;
        do begin
            @(negedge clk);
            cyc++;
            io_start_valid = 1'b0; io_cfg_node_we = 1'b0;
            if (io_req_valid) saw_req = 1;
        end while (!io_out_valid && cyc < 20);
        n_cmp++;
        if (!io_out_valid || cyc !== 2 || io_out_bits_class !== 8'h55 || saw_req) begin
            n_bad++;
            $display("FAIL start_with_write: out_valid=%b at %0d class=%h req_seen=%0d, required 1 2 55 0",
                     io_out_valid, cyc, io_out_bits_class, saw_req);
        end
        io_out_ready = 1'b1;
        @(negedge clk);
        io_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_traversal;
        int bad;
        write_node(4'd0, 1'b0, 8'h00, 3'd1, 32'd10, 4'd1, 4'd2);
        @(negedge clk);
        io_start_valid = 1'b1;
        @(negedge clk);
        io_start_valid = 1'b0;
        io_req_ready = io_req_valid;
        @(negedge clk);
        io_req_ready = 1'b0;
        n_cmp++;
        if (io_resp_ready !== 1'b1) begin
            n_bad++; $display("FAIL reach_wait: resp_ready=%b, required 1", io_resp_ready);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (io_start_ready !== 1'b1 || io_resp_ready !== 1'b0 || io_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: start_ready=%b resp_ready=%b out_valid=%b, required 1 0 0",
                     io_start_ready, io_resp_ready, io_out_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        io_resp_valid = 1'b1; io_resp_bits_index = 4'd0; io_resp_bits_decision = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (io_out_valid !== 1'b0 || io_start_ready !== 1'b1 || io_req_valid !== 1'b0 || io_resp_ready !== 1'b0)
                bad++;
        end
        io_resp_valid = 1'b0;
        n_cmp++;
        if (bad !== 0) begin
            n_bad++; $display("FAIL stale_resp_after_reset: %0d bad cycles, required 0", bad);
        end
        traverse(0, 0, 0, 0);
        n_cmp++;
        if (t_err !== 1'b1 || t_depth !== 5'd16 || t_nreq !== 16 || t_w[0] !== 32'd0 || t_feat[0] !== 32'd0) begin
            n_bad++;
            $display("FAIL table_cleared: err=%b depth=%0d reqs=%0d w0=%h f0=%h, required 1 16 16 0 0",
                     t_err, t_depth, t_nreq, t_w[0], t_feat[0]);
        end
    endtask

    initial begin
        test_reset();
        test_root_leaf();
        test_depth2();
        test_backpressure();
        test_bad_index();
        test_cfg_ignored();
        test_loop();
        test_start_and_write();
        test_reset_mid_traversal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
